// File: rtl/llpm_pkg.sv
// Shared constants and helpers for the LLPM route stage.
// Holds the per-output buffer depth and the handshake transfer test.
package llpm_pkg;

  localparam int unsigned Depth = 2;

  function automatic logic xfer(
    input logic valid,
    input logic bp
  );
    return valid & ~bp;
  endfunction

endpackage

// File: rtl/llpm_idx_route_buf_if.sv
// Handshake bundle for the index-steered route stage.
// master = producers/consumers side, slave = route stage.
interface llpm_idx_route_buf_if #(
  parameter int Width           = 8,
  parameter int NumOutputs      = 4,
  parameter int CLog2NumOutputs = 2
);

  logic [CLog2NumOutputs-1:0]         idx;
  logic                               idx_valid;
  logic                               idx_bp;
  logic [Width-1:0]                   x;
  logic                               x_valid;
  logic                               x_bp;
  logic [NumOutputs-1:0][Width-1:0]   a;
  logic [NumOutputs-1:0]              a_valid;
  logic [NumOutputs-1:0]              a_bp;
  logic                               drop_err;

  modport master (
    output idx, idx_valid, x, x_valid, a_bp,
    input  idx_bp, x_bp, a, a_valid, drop_err
  );

  modport slave (
    input  idx, idx_valid, x, x_valid, a_bp,
    output idx_bp, x_bp, a, a_valid, drop_err
  );

endinterface

// File: rtl/llpm_buf2.sv
// Two-entry in-order valid/bp FIFO used on each routed output.
// Head data comes straight from storage; storage itself is not reset.
module llpm_buf2
  import llpm_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [Width-1:0] in_data,
  output logic             full,
  output logic             out_valid,
  output logic [Width-1:0] out_data,
  input  logic             out_bp
);

  logic [Width-1:0] mem [Depth];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             deq;

  assign out_valid = (count != 2'd0);
  assign full      = (count == 2'(Depth));
  assign out_data  = mem[rd_ptr];
  assign deq       = xfer(out_valid, out_bp);

  // Pointers and occupancy; enqueue is pre-qualified by the caller.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (in_valid) wr_ptr <= ~wr_ptr;
      if (deq)      rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, in_valid} - {1'b0, deq};
    end
  end

  // Data storage written at the tail.
  always_ff @(posedge clk) begin
    if (in_valid) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/llpm_idx_route_buf.sv
// Index-steered route stage: joins idx and x, decodes the target,
// and drops out-of-range tokens with a one-cycle error pulse.
module llpm_idx_route_buf
  import llpm_pkg::*;
#(
  parameter int Width           = 8,
  parameter int NumOutputs      = 4,
  parameter int CLog2NumOutputs = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  llpm_idx_route_buf_if.slave  bus
);

  logic [NumOutputs-1:0]            sel;
  logic [NumOutputs-1:0]            full;
  logic [NumOutputs-1:0]            enq;
  logic [NumOutputs-1:0]            a_valid;
  logic [NumOutputs-1:0][Width-1:0] a_data;
  logic                             in_range;
  logic                             tgt_full;
  logic                             bp;
  logic                             fire;
  logic                             drop;
  logic                             drop_q;

  // One-hot target decode; no bit set means idx is out of range.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NumOutputs; i++) begin
      sel[i] = (bus.idx == CLog2NumOutputs'(i));
    end
  end

  assign in_range = |sel;
  assign tgt_full = |(sel & full);

  assign bp   = ~resetn | ~bus.idx_valid | ~bus.x_valid | tgt_full;
  assign fire = xfer(bus.idx_valid & bus.x_valid, bp);
  assign enq  = fire ? sel : '0;
  assign drop = fire & ~in_range;

  assign bus.idx_bp   = bp;
  assign bus.x_bp     = bp;
  assign bus.a        = a_data;
  assign bus.a_valid  = a_valid;
  assign bus.drop_err = drop_q;

  // Pulse drop_err for the cycle after a discarded token.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) drop_q <= 1'b0;
    else         drop_q <= drop;
  end

  for (genvar g = 0; g < NumOutputs; g++) begin : g_out
    llpm_buf2 #(
      .Width(Width)
    ) u_buf (
      .clk      (clk),
      .resetn   (resetn),
      .in_valid (enq[g]),
      .in_data  (bus.x),
      .full     (full[g]),
      .out_valid(a_valid[g]),
      .out_data (a_data[g]),
      .out_bp   (bus.a_bp[g])
    );
  end

endmodule

// File: tb/tb_llpm_idx_route_buf.sv
// Directed bench for the LLPM route stage.
// Covers a 4-output instance and a 3-output instance.
module tb_llpm_idx_route_buf;

  logic clk;
  logic resetn;

  int n_chk;
  int n_fail;

  llpm_idx_route_buf_if #(
    .Width(8), .NumOutputs(4), .CLog2NumOutputs(2)
  ) bus ();

  llpm_idx_route_buf_if #(
    .Width(8), .NumOutputs(3), .CLog2NumOutputs(2)
  ) bus3 ();

  llpm_idx_route_buf #(
    .Width(8), .NumOutputs(4), .CLog2NumOutputs(2)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  llpm_idx_route_buf #(
    .Width(8), .NumOutputs(3), .CLog2NumOutputs(2)
  ) dut3 (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] i, input logic [7:0] d);
    bus.idx       = i;
    bus.x         = d;
    bus.idx_valid = 1'b1;
    bus.x_valid   = 1'b1;
  endtask

  task automatic idle();
    bus.idx_valid = 1'b0;
    bus.x_valid   = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    resetn = 1'b0;
    bus.idx = '0;  bus.x = '0;
    bus.idx_valid = 1'b0; bus.x_valid = 1'b0;
    bus.a_bp = '0;
    bus3.idx = '0; bus3.x = '0;
    bus3.idx_valid = 1'b0; bus3.x_valid = 1'b0;
    bus3.a_bp = '0;

    // reset state
    @(negedge clk);
    bus.idx_valid = 1'b1;
    bus.x_valid   = 1'b1;
    #1;
    check("rst_a_valid", 32'(bus.a_valid), 32'h0);
    check("rst_drop", 32'(bus.drop_err), 32'h0);
    check("rst_idx_bp", 32'(bus.idx_bp), 32'h1);
    check("rst_x_bp", 32'(bus.x_bp), 32'h1);

    // first transfer right after reset release
    send(2'd2, 8'hA5);
    resetn = 1'b1;
    #1;
    check("first_bp", 32'(bus.idx_bp), 32'h0);
    step();
    check("first_valid", 32'(bus.a_valid), 32'h4);
    check("first_data", 32'(bus.a[2]), 32'hA5);
    idle();
    step();
    check("first_drain", 32'(bus.a_valid), 32'h0);

    // fill stalled output 1, then release
    bus.a_bp = 4'b0010;
    send(2'd1, 8'h11);
    #1;
    check("o1_bp0", 32'(bus.x_bp), 32'h0);
    step();
    send(2'd1, 8'h22);
    #1;
    check("o1_bp1", 32'(bus.x_bp), 32'h0);
    step();
    send(2'd1, 8'h33);
    #1;
    check("o1_full_idx_bp", 32'(bus.idx_bp), 32'h1);
    check("o1_full_x_bp", 32'(bus.x_bp), 32'h1);
    check("o1_head", 32'(bus.a[1]), 32'h11);
    check("o1_valid", 32'(bus.a_valid), 32'h2);
    step();
    bus.a_bp = 4'b0000;
    #1;
    check("o1_no_comb_bp", 32'(bus.x_bp), 32'h1);
    check("o1_head_held", 32'(bus.a[1]), 32'h11);
    step();
    check("o1_second", 32'(bus.a[1]), 32'h22);
    check("o1_bp_open", 32'(bus.x_bp), 32'h0);
    step();
    idle();
    check("o1_third", 32'(bus.a[1]), 32'h33);
    check("o1_third_v", 32'(bus.a_valid), 32'h2);
    step();
    check("o1_empty", 32'(bus.a_valid), 32'h0);

    // idx without x never transfers
    for (int k = 0; k < 3; k++) begin
      bus.idx       = 2'd3;
      bus.idx_valid = 1'b1;
      bus.x_valid   = 1'b0;
      #1;
      check("join_bp", 32'(bus.idx_bp), 32'h1);
      step();
      check("join_no_valid", 32'(bus.a_valid), 32'h0);
    end
    idle();

    // output 0 full and stalled, output 3 flows
    bus.a_bp = 4'b0001;
    send(2'd0, 8'h40);
    step();
    send(2'd0, 8'h41);
    step();
    send(2'd0, 8'h42);
    #1;
    check("o0_full_bp", 32'(bus.idx_bp), 32'h1);
    for (int k = 0; k < 3; k++) begin
      send(2'd3, 8'(8'hC0 + k));
      #1;
      check("o3_bp", 32'(bus.x_bp), 32'h0);
      step();
      check("o3_valid", 32'(bus.a_valid), 32'h9);
      check("o3_data", 32'(bus.a[3]), 32'(8'hC0 + k));
      check("o0_held", 32'(bus.a[0]), 32'h40);
    end
    idle();
    step();
    check("o0_only", 32'(bus.a_valid), 32'h1);
    bus.a_bp = 4'b0000;
    step();
    check("o0_second", 32'(bus.a[0]), 32'h41);
    check("o0_second_v", 32'(bus.a_valid), 32'h1);
    step();
    check("o0_empty", 32'(bus.a_valid), 32'h0);

    // out-of-range idx on the 3-output instance
    bus3.idx       = 2'd3;
    bus3.x         = 8'h77;
    bus3.idx_valid = 1'b1;
    bus3.x_valid   = 1'b1;
    #1;
    check("oor_bp", 32'(bus3.idx_bp), 32'h0);
    step();
    bus3.idx_valid = 1'b0;
    bus3.x_valid   = 1'b0;
    check("oor_drop", 32'(bus3.drop_err), 32'h1);
    check("oor_no_valid", 32'(bus3.a_valid), 32'h0);
    step();
    check("oor_drop_end", 32'(bus3.drop_err), 32'h0);
    bus3.idx       = 2'd2;
    bus3.x         = 8'h5C;
    bus3.idx_valid = 1'b1;
    bus3.x_valid   = 1'b1;
    step();
    bus3.idx_valid = 1'b0;
    bus3.x_valid   = 1'b0;
    check("n3_valid", 32'(bus3.a_valid), 32'h4);
    check("n3_data", 32'(bus3.a[2]), 32'h5C);
    check("n3_no_drop", 32'(bus3.drop_err), 32'h0);

    // async reset with outputs 0 and 2 full
    bus.a_bp = 4'b0101;
    send(2'd0, 8'h50); step();
    send(2'd2, 8'h60); step();
    send(2'd0, 8'h51); step();
    send(2'd2, 8'h61); step();
    check("pre_rst_valid", 32'(bus.a_valid), 32'h5);
    check("pre_rst_bp", 32'(bus.idx_bp), 32'h1);
    idle();
    #2;
    resetn = 1'b0;
    #1;
    check("async_valid", 32'(bus.a_valid), 32'h0);
    check("async_bp", 32'(bus.x_bp), 32'h1);
    #1;
    resetn = 1'b1;
    bus.a_bp = 4'b0000;
    step();
    check("post_rst_v0", 32'(bus.a_valid), 32'h0);
    step();
    check("post_rst_v1", 32'(bus.a_valid), 32'h0);
    send(2'd0, 8'h99);
    step();
    idle();
    check("post_rst_new_v", 32'(bus.a_valid), 32'h1);
    check("post_rst_new_d", 32'(bus.a[0]), 32'h99);
    step();
    check("post_rst_end", 32'(bus.a_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/llpm_idx_route_buf.md
LLPM_IDX_ROUTE_BUF -- requirements
Module: llpm_idx_route_buf

Interface
REQ-001 The block SHALL be the index-steered route (demux) stage feeding per-input channels of the LLPM select vertex, with a 2-entry buffer on every output.
REQ-002 Width, default 8, SHALL be the data bits per token.
REQ-003 NumOutputs, default 4, SHALL be the number of routed outputs (legal range 2..16).
REQ-004 CLog2NumOutputs, default 2, SHALL equal ceil(log2(NumOutputs)).
REQ-005 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-006 resetn  input  1  reset, asynchronous and active-low.
REQ-007 idx  input  CLog2NumOutputs  destination output number.
REQ-008 idx_valid  input  1  idx token present.
REQ-009 idx_bp  output  1  backpressure to the idx producer.
REQ-010 x  input  Width  data token.
REQ-011 x_valid  input  1  data token present.
REQ-012 x_bp  output  1  backpressure to the data producer.
REQ-013 a  output  NumOutputs x Width  per-output head data.
REQ-014 a_valid  output  NumOutputs  per-output head valid.
REQ-015 a_bp  input  NumOutputs  per-output consumer backpressure.
REQ-016 drop_err  output  1  registered one-cycle pulse for an out-of-range idx.

Function
REQ-017 A transfer on any channel SHALL occur in a cycle where its valid=1 and its bp=0; bp=1 never cancels a presented token.
REQ-018 idx and x SHALL be joined: both are consumed in the same cycle or neither is.
REQ-019 idx_bp and x_bp SHALL be identical: 1 when !idx_valid, !x_valid, or target buffer count==2; otherwise 0.
REQ-020 idx_bp and x_bp SHALL NOT depend combinationally on a_bp; a full buffer blocks input even if it drains in the same cycle.
REQ-021 Accepted tokens SHALL appear at a[idx] with a_valid[idx]=1 exactly one cycle after the accepting edge (latency 1).
REQ-022 Each output SHALL be an in-order 2-entry FIFO with count 0..2; a_valid[i] = (count[i]!=0); a[i] = head entry, driven from registers.
REQ-023 Output i SHALL dequeue when a_valid[i]=1 and a_bp[i]=0.
REQ-024 Enqueue and dequeue on the same output in one cycle at count==1 SHALL leave count=1 with the new token at the head.
REQ-025 count==0 with no enqueue SHALL hold a_valid[i]=0; the a[i] value is don't-care.
REQ-026 An idx >= NumOutputs SHALL be accepted (bp=0 when both inputs are valid), the token SHALL be discarded, and drop_err SHALL be 1 for the following cycle only.
REQ-027 Outputs SHALL be independent; a stalled output SHALL NOT block tokens routed to other outputs.
REQ-028 Write and read pointers SHALL be 1 bit each and SHALL wrap modulo 2.

Reset
REQ-029 While resetn=0, every count, pointer and drop_err SHALL be 0; all a_valid SHALL be 0; idx_bp and x_bp SHALL be 1.
REQ-030 Assertion of resetn mid-operation SHALL discard all buffered tokens immediately, without waiting for a clock edge.
REQ-031 Data storage SHALL NOT be reset.
REQ-032 The first transfer SHALL be possible on the first rising edge after resetn deasserts.

Structure
REQ-033 The package llpm_pkg SHALL hold the handshake-transfer helper function and the 2-entry depth constant.
REQ-034 One sub-module, llpm_buf2 (a 2-entry valid/bp FIFO with parameter Width), SHALL be instantiated once per output through a generate loop.
REQ-035 The top level SHALL contain only the join, decode, drop logic and the drop_err register.

Verification
REQ-036 Reset release, idx=2, x=0xA5, both valid, a_bp=0 -> a_valid=4'b0100 and a[2]=0xA5 one cycle later; a_valid=0 the cycle after that.
REQ-037 a_bp[1]=1; send 0x11, 0x22, 0x33 to output 1 -> first two accepted, idx_bp=x_bp=1 on the third; release a_bp[1] -> 0x11 then 0x22 delivered, then 0x33 accepted.
REQ-038 idx_valid=1 with x_valid=0 for 3 cycles -> idx_bp=1 throughout; no a_valid asserted.
REQ-039 Output 0 full and stalled; tokens sent to output 3 -> each delivered with latency 1; output 0 contents unchanged.
REQ-040 NumOutputs=3, idx=3 -> token accepted, drop_err pulses 1 cycle, no a_valid asserted.
REQ-041 resetn pulsed low between clock edges with outputs 0 and 2 holding 2 entries -> a_valid=0 immediately; after release, counts are 0 and no stale data is emitted.
